// File: rtl/dp_ram_pipelined.sv
// Simple dual-port RAM (1W/1R) with byte enables, 1- or 2-cycle read latency,
// selectable read-during-write result and a sequential clear engine.
module dp_ram_pipelined #(
  parameter int DATA_WIDTH   = 32,
  parameter int BYTE_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int BYPASS       = 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_init_req,
  output logic                             o_init_busy,
  input  logic                             i_wr_en,
  input  logic [ADDR_WIDTH-1:0]            i_wr_addr,
  input  logic [DATA_WIDTH-1:0]            i_wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_wr_be,
  input  logic                             i_rd_en,
  input  logic [ADDR_WIDTH-1:0]            i_rd_addr,
  output logic [DATA_WIDTH-1:0]            o_rd_data,
  output logic                             o_rd_valid
);
  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  generate
    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_bw
      $error("dp_ram_pipelined: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
      $error("dp_ram_pipelined: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  // array deliberately has no reset so it maps onto block RAM
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_clr_addr;

  logic                  w_idle;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_collide;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_data;
  logic [NB-1:0]         w_mem_be;
  logic [DATA_WIDTH-1:0] w_rd_old;
  logic [DATA_WIDTH-1:0] w_rd_word;

  logic [READ_LATENCY-1:0]                 r_vld_pipe;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] r_dat_pipe;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_wr_acc    = w_idle & i_wr_en;
  assign w_rd_acc    = w_idle & i_rd_en;
  assign o_init_busy = ~w_idle;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
    end else if (!w_idle) begin
      r_clr_addr <= r_clr_addr + 1'b1;
      if (r_clr_addr == {ADDR_WIDTH{1'b1}}) r_state <= ST_IDLE;
    end else if (i_init_req) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
    end
  end

  // the clear engine borrows the write port
  always_comb begin
    w_mem_we   = w_wr_acc;
    w_mem_addr = i_wr_addr;
    w_mem_data = i_wr_data;
    w_mem_be   = i_wr_be;
    if (!w_idle) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_clr_addr;
      w_mem_data = '0;
      w_mem_be   = '1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (w_mem_be[b]) r_mem[w_mem_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= w_mem_data[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign w_rd_old  = r_mem[i_rd_addr];
  assign w_collide = (BYPASS != 0) && w_wr_acc && (i_wr_addr == i_rd_addr);

  // on a bypassed collision only the enabled lanes take the new data
  generate
    for (genvar g = 0; g < NB; g++) begin : g_lane
      assign w_rd_word[g*BYTE_WIDTH +: BYTE_WIDTH] = (w_collide && i_wr_be[g])
        ? i_wr_data[g*BYTE_WIDTH +: BYTE_WIDTH]
        : w_rd_old[g*BYTE_WIDTH +: BYTE_WIDTH];
    end
  endgenerate

  // the last stage holds its data between reads; a clear flushes all valids
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_pipe <= '0;
      r_dat_pipe <= '0;
    end else if (!w_idle) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= w_rd_acc;
      if (w_rd_acc) r_dat_pipe[0] <= w_rd_word;
      for (int s = 1; s < READ_LATENCY; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        if (r_vld_pipe[s-1]) r_dat_pipe[s] <= r_dat_pipe[s-1];
      end
    end
  end

  assign o_rd_valid = r_vld_pipe[READ_LATENCY-1];
  assign o_rd_data  = r_dat_pipe[READ_LATENCY-1];

endmodule

// File: tb/tb_dp_ram_pipelined.sv
// Bench for dp_ram_pipelined: two instances (latency 1 + bypass, latency 2 + no bypass)
// share one stimulus stream and are compared every cycle against a word-level model.
module tb_dp_ram_pipelined;
  localparam int DW = 32, AW = 8, NB = 4, DEPTH = 256;

  logic          clk, rst_n, init_req, wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_be;
  logic          busy_a, valid_a, busy_b, valid_b;
  logic [DW-1:0] data_a, data_b;

  int n_cmp = 0, n_bad = 0, edge_n = 0;

  dp_ram_pipelined #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW), .READ_LATENCY(1), .BYPASS(1)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_init_req(init_req), .o_init_busy(busy_a),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_be(wr_be),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(data_a), .o_rd_valid(valid_a));

  dp_ram_pipelined #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW), .READ_LATENCY(2), .BYPASS(0)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_init_req(init_req), .o_init_busy(busy_b),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_be(wr_be),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(data_b), .o_rd_valid(valid_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: index 0 mirrors u_dut_a, index 1 mirrors u_dut_b
  int            lat_of [2] = '{1, 2};
  bit            byp_of [2] = '{1'b1, 1'b0};
  logic [DW-1:0] m_mem [2][DEPTH];
  bit            m_busy [2];
  int            m_clr [2];
  logic [DW-1:0] m_data [2];
  bit            m_valid [2];
  typedef struct {int k; int due; logic [DW-1:0] d;} pend_t;
  pend_t q[$];

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] d, input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < NB; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b1; m_clr[k] = 0; m_data[k] = '0; m_valid[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [DW-1:0] v;
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0;
      if (m_busy[k]) begin
        for (int j = q.size() - 1; j >= 0; j--) if (q[j].k == k) q.delete(j);
        m_mem[k][m_clr[k]] = '0;
        if (m_clr[k] == DEPTH - 1) begin m_busy[k] = 1'b0; m_clr[k] = 0; end
        else m_clr[k]++;
      end else begin
        if (rd_en) begin
          v = m_mem[k][rd_addr];
          if (byp_of[k] && wr_en && wr_addr == rd_addr) v = merge(v, wr_data, wr_be);
          q.push_back('{k, edge_n + lat_of[k] - 1, v});
        end
        if (wr_en) m_mem[k][wr_addr] = merge(m_mem[k][wr_addr], wr_data, wr_be);
        if (init_req) begin m_busy[k] = 1'b1; m_clr[k] = 0; end
        for (int j = 0; j < q.size(); j++) begin
          if (q[j].k == k && q[j].due == edge_n) begin
            m_valid[k] = 1'b1; m_data[k] = q[j].d; q.delete(j); break;
          end
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %h, expected %h", nm, edge_n, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("busy_a", busy_a, m_busy[0]);
    chk("valid_a", valid_a, m_valid[0]);
    chk("data_a", data_a, m_data[0]);
    chk("busy_b", busy_b, m_busy[1]);
    chk("valid_b", valid_b, m_valid[1]);
    chk("data_b", data_b, m_data[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    if (rst_n) model_edge();
    #1;
    compare_all();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_check(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    chk("lit rd valid_a", valid_a, 1); chk("lit rd data_a", data_a, exp);
    tick();
    chk("lit rd valid_b", valid_b, 1); chk("lit rd data_b", data_b, exp);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy_a && n < 400) begin tick(); n++; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen_a, seen_b;
    rst_n = 1'b1; init_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    for (int k = 0; k < 2; k++) for (int a = 0; a < DEPTH; a++) m_mem[k][a] = '0;

    // reset state
    #1 rst_n = 1'b0; model_reset();
    #2;
    chk("reset busy_a", busy_a, 1); chk("reset valid_a", valid_a, 0); chk("reset data_a", data_a, 0);
    chk("reset busy_b", busy_b, 1); chk("reset valid_b", valid_b, 0); chk("reset data_b", data_b, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    wait_idle(n);
    chk("reset clear cycles", n, 256);
    read_check(8'd0, 32'h0); read_check(8'd128, 32'h0); read_check(8'd255, 32'h0);

    // byte enables
    wr(8'd5, 32'hAABBCCDD, 4'hF);
    wr(8'd5, 32'h11223344, 4'b0101);
    read_check(8'd5, 32'hAA22CC44);
    wr(8'd5, 32'h00000000, 4'h0);
    read_check(8'd5, 32'hAA22CC44);

    // latency: back-to-back reads of 1, 2, 3
    wr(8'd1, 32'h11111111, 4'hF); wr(8'd2, 32'h22222222, 4'hF); wr(8'd3, 32'h33333333, 4'hF);
    rd_en = 1'b1; rd_addr = 8'd1; tick();
    chk("lat1 v_a", valid_a, 1); chk("lat1 d_a", data_a, 32'h11111111); chk("lat1 v_b", valid_b, 0);
    rd_addr = 8'd2; tick();
    chk("lat2 d_a", data_a, 32'h22222222); chk("lat2 v_b", valid_b, 1); chk("lat2 d_b", data_b, 32'h11111111);
    rd_addr = 8'd3; tick();
    chk("lat3 d_a", data_a, 32'h33333333); chk("lat3 d_b", data_b, 32'h22222222);
    rd_en = 1'b0; tick();
    chk("lat4 v_a", valid_a, 0); chk("lat4 v_b", valid_b, 1); chk("lat4 d_b", data_b, 32'h33333333);
    tick();
    chk("lat5 v_b", valid_b, 0); chk("lat5 hold d_b", data_b, 32'h33333333);

    // collision on address 7 (cleared to zero)
    wr_en = 1'b1; wr_addr = 8'd7; wr_data = 32'hFFFFFFFF; wr_be = 4'b0011;
    rd_en = 1'b1; rd_addr = 8'd7;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("coll v_a", valid_a, 1); chk("coll bypass d_a", data_a, 32'h0000FFFF);
    tick();
    chk("coll v_b", valid_b, 1); chk("coll old d_b", data_b, 32'h00000000);
    read_check(8'd7, 32'h0000FFFF);

    // init_req with a read in flight; traffic during the clear is ignored
    init_req = 1'b1; rd_en = 1'b1; rd_addr = 8'd3;
    tick();
    init_req = 1'b0;
    wr_en = 1'b1; wr_addr = 8'd9; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
    n = 0; seen_a = 1'b0; seen_b = 1'b0;
    while (busy_a && n < 400) begin
      rd_addr = n[7:0]; wr_addr = n[7:0];
      tick(); n++;
      if (valid_a) seen_a = 1'b1;
      if (valid_b) seen_b = 1'b1;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    chk("init clear cycles", n, 256);
    chk("valid_a during clear", seen_a, 0);
    chk("flushed valid_b", seen_b, 0);
    rd_en = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin rd_addr = a[7:0]; tick(); end
    rd_en = 1'b0; tick(); tick();
    read_check(8'd9, 32'h0); read_check(8'd5, 32'h0);

    // reset at clear cycle 100
    wr(8'd200, 32'h12345678, 4'hF);
    read_check(8'd200, 32'h12345678);
    init_req = 1'b1; tick(); init_req = 1'b0;
    repeat (100) tick();
    rst_n = 1'b0; model_reset();
    #1;
    chk("midclr data_a", data_a, 0); chk("midclr valid_a", valid_a, 0);
    chk("midclr data_b", data_b, 0); chk("midclr busy_b", busy_b, 1);
    tick(); tick(); tick();
    rst_n = 1'b1;
    wait_idle(n);
    chk("restart clear cycles", n, 256);
    read_check(8'd200, 32'h0);
    read_check(8'd50, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
